// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS core.
// Sequences the shared datapath (single memory port, single ALU, IR/A/B/ALUOut/MDR)
// through fetch, decode, execute, memory and write-back states. All datapath
// controls are Moore outputs of the current state; the only input-dependent
// output is pc_en, which folds in the ALU zero flag during BRANCH.
// Also keeps a sticky illegal-opcode flag and a retired-instruction counter.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  // Opcodes understood by the decoder; everything else is illegal.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function code that turns an R-type into a register jump.
  localparam logic [5:0] FN_JR    = 6'b001000;

  // ALU operation classes consumed by the downstream ALU decoder.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-operand selections.
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source selections.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  // State encoding is visible on the debug port, so the codes are fixed.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JR        = 4'd12
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] instret_reg;
  logic [CNT_W-1:0] instret_next;
  logic             illegal_reg;
  logic             illegal_next;

  // Raw Moore controls before the reset gate on the strobes.
  logic       pc_write;
  logic       pc_write_cond;
  logic       mem_read_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic [1:0] pc_source_raw;
  logic       iord_raw;
  logic       reg_dst_raw;
  logic       mem_to_reg_raw;
  logic       alu_src_a_raw;
  logic [1:0] alu_src_b_raw;
  logic [1:0] alu_op_raw;

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Retired-instruction counter and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_reg <= '0;
      illegal_reg <= 1'b0;
    end else begin
      instret_reg <= instret_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state, bookkeeping and Moore output decode for the current state.
  always_comb begin
    state_next     = S_FETCH;
    instret_next   = instret_reg;
    illegal_next   = illegal_reg;
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    mem_read_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    pc_source_raw  = PCSRC_ALU;
    iord_raw       = 1'b0;
    reg_dst_raw    = 1'b0;
    mem_to_reg_raw = 1'b0;
    alu_src_a_raw  = 1'b0;
    alu_src_b_raw  = SRCB_REG;
    alu_op_raw     = ALU_ADD;

    case (state_reg)
      S_FETCH: begin
        // Read instruction at PC into IR while the ALU computes PC+4.
        mem_read_raw  = 1'b1;
        ir_write_raw  = 1'b1;
        alu_src_b_raw = SRCB_FOUR;
        alu_op_raw    = ALU_ADD;
        pc_write      = 1'b1;
        pc_source_raw = PCSRC_ALU;
        state_next    = S_DECODE;
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b_raw = SRCB_IMMSH;
        alu_op_raw    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = (funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default: begin
            // Unknown opcode: drop it and refetch; it never retires.
            state_next   = S_FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = SRCB_IMM;
        alu_op_raw    = ALU_ADD;
        state_next    = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_read_raw = 1'b1;
        iord_raw     = 1'b1;
        state_next   = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = 1'b1;
        state_next     = S_FETCH;
        instret_next   = instret_reg + CNT_W'(1);
      end

      S_MEM_WRITE: begin
        mem_write_raw = 1'b1;
        iord_raw      = 1'b1;
        state_next    = S_FETCH;
        instret_next  = instret_reg + CNT_W'(1);
      end

      S_EXECUTE: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = SRCB_REG;
        alu_op_raw    = ALU_FUNCT;
        state_next    = S_R_WB;
      end

      S_R_WB: begin
        reg_write_raw = 1'b1;
        reg_dst_raw   = 1'b1;
        state_next    = S_FETCH;
        instret_next  = instret_reg + CNT_W'(1);
      end

      S_BRANCH: begin
        // ALU compares A and B; PC takes ALUOut only when they are equal.
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = SRCB_REG;
        alu_op_raw    = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source_raw = PCSRC_ALUOUT;
        state_next    = S_FETCH;
        instret_next  = instret_reg + CNT_W'(1);
      end

      S_JUMP: begin
        pc_write      = 1'b1;
        pc_source_raw = PCSRC_JUMP;
        state_next    = S_FETCH;
        instret_next  = instret_reg + CNT_W'(1);
      end

      S_ADDI_EXEC: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = SRCB_IMM;
        alu_op_raw    = ALU_ADD;
        state_next    = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        // rt destination, ALUOut source: both selects stay at 0.
        reg_write_raw = 1'b1;
        state_next    = S_FETCH;
        instret_next  = instret_reg + CNT_W'(1);
      end

      S_JR: begin
        pc_write      = 1'b1;
        pc_source_raw = PCSRC_REGA;
        state_next    = S_FETCH;
        instret_next  = instret_reg + CNT_W'(1);
      end

      default: begin
        // Unreachable codes recover to FETCH without retiring anything.
        state_next = S_FETCH;
      end
    endcase
  end

  // Strobes that change architectural state are held off while reset is
  // asserted, even though the reset state (FETCH) would otherwise raise them.
  assign pc_en      = (pc_write | (pc_write_cond & zero)) & rst_n;
  assign mem_read   = mem_read_raw  & rst_n;
  assign mem_write  = mem_write_raw & rst_n;
  assign ir_write   = ir_write_raw  & rst_n;
  assign reg_write  = reg_write_raw & rst_n;

  // Mux selects and ALU class are harmless during reset and pass straight out.
  assign pc_source  = pc_source_raw;
  assign iord       = iord_raw;
  assign reg_dst    = reg_dst_raw;
  assign mem_to_reg = mem_to_reg_raw;
  assign alu_src_a  = alu_src_a_raw;
  assign alu_src_b  = alu_src_b_raw;
  assign alu_op     = alu_op_raw;

  assign state      = state_reg;
  assign illegal_op = illegal_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: spec-table vectors, hand-written
// reset-abort sequences, and randomized instruction streams checked against a
// per-instruction-class reference model.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             pc_en;
  logic [1:0]       pc_source;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instret;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .pc_source(pc_source), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .illegal_op(illegal_op), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [CNT_W-1:0] model_instret;
  logic             model_illegal;
  int               exp_seq [8];
  int               exp_len;

  // Per-state control table from the output list: pc write kinds plus
  // {pc_source, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b, alu_op}.
  logic        tab_pcw  [16];
  logic        tab_pcc  [16];
  logic [13:0] tab_ctrl [16];

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         zmode;   // 0 or 1: fixed zero, 2: random each cycle
    int         lat;     // documented latency in cycles including FETCH
  } vec_t;

  vec_t vecs [12];

  function automatic logic [13:0] row(input logic [1:0] psrc, input logic io,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic rw, input logic rd, input logic m2r,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] aop);
    return {psrc, io, mr, mw, irw, rw, rd, m2r, asa, asb, aop};
  endfunction

  // Instruction-class model: the list of states an instruction visits.
  task automatic build_seq(input logic [5:0] op, input logic [5:0] fn);
    exp_seq[0] = 0;
    exp_seq[1] = 1;
    case (op)
      6'b100011: begin exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 4; exp_len = 5; end
      6'b101011: begin exp_seq[2] = 2; exp_seq[3] = 5; exp_len = 4; end
      6'b000000: begin
        if (fn == 6'b001000) begin exp_seq[2] = 12; exp_len = 3; end
        else begin exp_seq[2] = 6; exp_seq[3] = 7; exp_len = 4; end
      end
      6'b000100: begin exp_seq[2] = 8; exp_len = 3; end
      6'b000010: begin exp_seq[2] = 9; exp_len = 3; end
      6'b001000: begin exp_seq[2] = 10; exp_seq[3] = 11; exp_len = 4; end
      default:   exp_len = 2;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [14:0] dut_ctrl();
    return {pc_en, pc_source, iord, mem_read, mem_write, ir_write, reg_write,
            reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op};
  endfunction

  function automatic logic [4:0] dut_strobes();
    return {pc_en, ir_write, mem_read, mem_write, reg_write};
  endfunction

  // Runs one instruction starting in FETCH; checks every cycle's state and
  // controls, the cycle count back to FETCH, and the counters afterwards.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int lat_exp);
    int lat;
    logic z;
    lat = 0;
    opcode = op;
    funct  = fn;
    build_seq(op, fn);
    for (int k = 0; k < exp_len; k++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      zero = z;
      #1;
      check($sformatf("cycle%0d_state_ctrl", k), {13'b0, state, dut_ctrl()},
            {13'b0, 4'(exp_seq[k]),
             tab_pcw[exp_seq[k]] | (tab_pcc[exp_seq[k]] & z), tab_ctrl[exp_seq[k]]});
      @(posedge clk);
      #1;
      if (lat == 0 && state == 4'd0) lat = k + 1;
    end
    if (exp_len == 2) model_illegal = 1'b1;
    else model_instret = model_instret + 1'b1;
    check("latency", 32'(lat), 32'(lat_exp));
    check("instret", 32'(instret), 32'(model_instret));
    check("illegal_op", 32'(illegal_op), 32'(model_illegal));
    $display("instr op=%b fn=%b cycles=%0d instret=%0d illegal_op=%0b",
             op, fn, lat, instret, illegal_op);
  endtask

  // Drives an instruction until the given state, then asserts reset mid-cycle.
  task automatic abort_at(input logic [5:0] op, input logic [3:0] target);
    int n;
    opcode = op;
    funct  = 6'b0;
    zero   = 1'b0;
    n = 0;
    while (state != target && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("reach_state%0d", target), 32'(state), 32'(target));
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_strobes", 32'(dut_strobes()), 32'd0);
    check("abort_counters", {27'b0, illegal_op, instret}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_hold_state", 32'(state), 32'd0);
    check("abort_hold_strobes", 32'(dut_strobes()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_instret = '0;
    model_illegal = 1'b0;
    #1;
    check("post_release_fetch", {27'b0, state, mem_read},
          {27'b0, 4'd0, 1'b1});
    $display("reset abort in state %0d", target);
  endtask

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Control table for each state, from the output list.
    for (int s = 0; s < 16; s++) begin
      tab_pcw[s]  = 1'b0;
      tab_pcc[s]  = 1'b0;
      tab_ctrl[s] = '0;
    end
    tab_pcw[0]   = 1'b1;
    tab_ctrl[0]  = row(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00);
    tab_ctrl[1]  = row(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00);
    tab_ctrl[2]  = row(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00);
    tab_ctrl[3]  = row(2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tab_ctrl[4]  = row(2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00);
    tab_ctrl[5]  = row(2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tab_ctrl[6]  = row(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10);
    tab_ctrl[7]  = row(2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00);
    tab_pcc[8]   = 1'b1;
    tab_ctrl[8]  = row(2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01);
    tab_pcw[9]   = 1'b1;
    tab_ctrl[9]  = row(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    tab_ctrl[10] = row(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00);
    tab_ctrl[11] = row(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    tab_pcw[12]  = 1'b1;
    tab_ctrl[12] = row(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);

    // Directed vectors with the documented latencies.
    vecs[0]  = '{op: 6'b100011, fn: 6'b000000, zmode: 2, lat: 5};  // lw
    vecs[1]  = '{op: 6'b000000, fn: 6'b100000, zmode: 2, lat: 4};  // add
    vecs[2]  = '{op: 6'b101011, fn: 6'b000000, zmode: 2, lat: 4};  // sw
    vecs[3]  = '{op: 6'b000100, fn: 6'b000000, zmode: 1, lat: 3};  // beq taken
    vecs[4]  = '{op: 6'b000100, fn: 6'b000000, zmode: 0, lat: 3};  // beq not taken
    vecs[5]  = '{op: 6'b000010, fn: 6'b000000, zmode: 2, lat: 3};  // j
    vecs[6]  = '{op: 6'b000000, fn: 6'b001000, zmode: 2, lat: 3};  // jr
    vecs[7]  = '{op: 6'b001000, fn: 6'b000000, zmode: 2, lat: 4};  // addi
    vecs[8]  = '{op: 6'b111111, fn: 6'b000000, zmode: 2, lat: 2};  // illegal
    vecs[9]  = '{op: 6'b100011, fn: 6'b001000, zmode: 2, lat: 5};  // lw, flag stays
    vecs[10] = '{op: 6'b000001, fn: 6'b000000, zmode: 1, lat: 2};  // illegal
    vecs[11] = '{op: 6'b000000, fn: 6'b101010, zmode: 2, lat: 4};  // slt

    // Reset: strobes held low although the machine sits in FETCH.
    rst_n = 1'b0;
    opcode = 6'b0;
    funct  = 6'b0;
    zero   = 1'b0;
    model_instret = '0;
    model_illegal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_strobes", 32'(dut_strobes()), 32'd0);
    check("reset_counters", {27'b0, illegal_op, instret}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].zmode, vecs[i].lat);

    // Random stream; long enough to wrap the narrow counter.
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int sel;
      sel = int'($urandom_range(0, 7));
      fn  = 6'($urandom);
      case (sel)
        0: begin op = 6'b000000; if ($urandom_range(0, 3) == 0) fn = 6'b001000; end
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      build_seq(op, fn);
      run_instr(op, fn, 2, exp_len);
    end

    // Reset in the middle of an instruction.
    run_instr(6'b110011, 6'b0, 2, 2);
    abort_at(6'b100011, 4'd4);
    run_instr(6'b100011, 6'b0, 2, 5);
    run_instr(6'b111111, 6'b0, 2, 2);
    abort_at(6'b001000, 4'd10);
    run_instr(6'b001000, 6'b0, 2, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
